loop_sampler: RTL
=================

LOOP_SAMPLER -- requirements
Module: loop_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of debiased bits per output word.
REQ-002 SHALL have parameter SAMPLE_DIV, default 16: clock cycles between oscillator samples; legal range 2..256.
REQ-003 SHALL have parameter SEED_CYCLES, default 4: cycles the loop is held in seed mode before free-running; legal range 1..256.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  level request to run the loop and collect entropy.
REQ-007 SHALL have port osc_in  input  1  asynchronous output d of the inverter loop.
REQ-008 SHALL have port ctrl  output  1  drives the loop ctrl input; 1 = loop held at seed, 0 = loop oscillates.
REQ-009 SHALL have port seed  output  1  drives the loop seed input; constant 0.
REQ-010 SHALL have port entropy_data  output  WIDTH  collected word.
REQ-011 SHALL have port entropy_valid  output  1  entropy_data holds a complete word.
REQ-012 SHALL have port entropy_ack  input  1  consumer accepts the word; only meaningful while entropy_valid=1.

Function
REQ-013 SHALL pass osc_in through a two-flop synchronizer; only the second flop output (osc_sync) is used.
REQ-014 SHALL implement states IDLE, SEED, RUN, FULL; ctrl=1 in IDLE and SEED, ctrl=0 in RUN and FULL; all outputs registered.
REQ-015 IDLE: bit count, divider, pair flag cleared; enable=1 -> SEED next edge.
REQ-016 SEED: remain exactly SEED_CYCLES cycles, then -> RUN; divider and pair flag cleared on RUN entry.
REQ-017 RUN: divider counts 0..SAMPLE_DIV-1, wraps to 0; sample tick when divider = SAMPLE_DIV-1; first tick SAMPLE_DIV cycles after RUN entry.
REQ-018 Von Neumann: odd tick stores osc_sync as bit a and sets pair flag; even tick takes b = osc_sync, clears pair flag; if a != b, entropy_data <= {entropy_data[WIDTH-2:0], a} and bit count increments; if a == b, pair is discarded with no other effect.
REQ-019 When an accepted bit brings bit count to WIDTH, -> FULL on that edge; entropy_valid=1 from that edge.
REQ-020 FULL: divider frozen, no sampling, entropy_data stable; missed oscillator samples are discarded, not queued.
REQ-021 FULL with entropy_ack=1: -> RUN, entropy_valid=0 and bit count, divider, pair flag cleared on that edge; entropy_data retains old value until overwritten by shifting.
REQ-022 entropy_ack while entropy_valid=0 SHALL be ignored.
REQ-023 enable=0 in any state SHALL -> IDLE next edge, clearing entropy_valid and entropy_data; takes priority over simultaneous entropy_ack or word completion.
REQ-024 Bit count width SHALL be clog2(WIDTH+1); divider width clog2(SAMPLE_DIV); no wrap-around of bit count beyond WIDTH.

Reset
REQ-025 reset=1 SHALL immediately force: state IDLE, ctrl=1, seed=0, entropy_valid=0, entropy_data=0, synchronizer flops=0, all counters and pair flag 0.
REQ-026 Reset asserted mid-operation (any state) SHALL discard the partial or completed word; after release, collection restarts from IDLE/SEED.

Verification (bench parameters WIDTH=8, SAMPLE_DIV=4, SEED_CYCLES=4)
REQ-027 Reset: assert reset with enable=1 -> ctrl=1, seed=0, entropy_valid=0, entropy_data=8'h00 without clock edge.
REQ-028 Startup: enable rises, edge 0 enters SEED -> ctrl=1 for 4 cycles, ctrl=0 from edge 4; first sample tick at edge 8.
REQ-029 Debias: osc_in drives sample pairs (1,0)x8 -> entropy_data=8'hFF, valid=1; pairs (0,1)x8 -> 8'h00; alternating (1,0),(0,1) -> 8'hAA; pairs (0,0)/(1,1)x20 -> valid stays 0, data unchanged.
REQ-030 Backpressure: valid=1, no ack for 100 cycles while osc_in toggles -> data constant, valid held; ack pulse -> valid=0 next edge, next word after 8 further accepted pairs.
REQ-031 Abort: drop enable after 5 accepted bits -> IDLE, ctrl=1, data=0; re-enable -> full SEED then 8 fresh bits before valid.
REQ-032 Priority: in FULL assert enable=0 and entropy_ack same cycle -> IDLE, valid=0, data=0; reset asserted in FULL -> same outputs asynchronously.

Source files
------------

// File: rtl/loop_sampler.sv
// Ring-oscillator entropy sampler: seeds and releases an inverter loop, samples it
// on a slow divider tick, and debiases the samples with a Von Neumann extractor.
module loop_sampler #(
  parameter int WIDTH       = 32,
  parameter int SAMPLE_DIV  = 16,
  parameter int SEED_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             osc_in,
  output logic             ctrl,
  output logic             seed,
  output logic [WIDTH-1:0] entropy_data,
  output logic             entropy_valid,
  input  logic             entropy_ack
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int SEED_W = $clog2(SEED_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_FULL
  } state_e;

  logic              sync1_q, sync2_q;
  logic              osc_sync;
  state_e            state_q, state_d;
  logic [SEED_W-1:0] seed_cnt_q, seed_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              pair_q, pair_d;
  logic              bit_a_q, bit_a_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              ctrl_q, ctrl_d;

  // The loop output is fully asynchronous; only the second flop is trusted.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
    end
  end

  assign osc_sync = sync2_q;

  always_comb begin
    // NOTE: every next-state signal defaults to its register first so no path
    // through the case leaves a value unassigned (which would infer a latch).
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    pair_d     = pair_q;
    bit_a_d    = bit_a_q;
    data_d     = data_q;
    valid_d    = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        seed_cnt_d = '0;
        div_d      = '0;
        bit_cnt_d  = '0;
        pair_d     = 1'b0;
        if (enable) state_d = ST_SEED;
      end

      ST_SEED: begin
        if (seed_cnt_q == SEED_LAST) begin
          state_d = ST_RUN;
          div_d   = '0;
          pair_d  = 1'b0;
        end else begin
          seed_cnt_d = seed_cnt_q + SEED_W'(1);
        end
      end

      ST_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!pair_q) begin
            bit_a_d = osc_sync;
            pair_d  = 1'b1;
          end else begin
            pair_d = 1'b0;
            // Equal pairs carry bias, so only differing pairs yield a bit.
            if (bit_a_q != osc_sync) begin
              data_d    = {data_q[WIDTH-2:0], bit_a_q};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CNT_LAST) begin
                state_d = ST_FULL;
                valid_d = 1'b1;
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_FULL: begin
        if (entropy_ack) begin
          state_d   = ST_RUN;
          valid_d   = 1'b0;
          bit_cnt_d = '0;
          div_d     = '0;
          pair_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Dropping enable wins over completion and acknowledge alike.
    if (!enable) begin
      state_d    = ST_IDLE;
      valid_d    = 1'b0;
      data_d     = '0;
      seed_cnt_d = '0;
      div_d      = '0;
      bit_cnt_d  = '0;
      pair_d     = 1'b0;
    end

    ctrl_d = (state_d == ST_IDLE) || (state_d == ST_SEED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      seed_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      pair_q     <= 1'b0;
      bit_a_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ctrl_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      pair_q     <= pair_d;
      bit_a_q    <= bit_a_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign ctrl          = ctrl_q;
  assign seed          = 1'b0;
  assign entropy_data  = data_q;
  assign entropy_valid = valid_q;

endmodule
